// File: rtl/conv_out_pkg.sv
// Shared types and constants for the convolution output writer.
package conv_out_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int unsigned DEF_ACC_WIDTH   = 32;
  localparam int unsigned DEF_DATA_WIDTH  = 20;
  localparam int unsigned DEF_ADDR_WIDTH  = 10;
  localparam int unsigned DEF_SHIFT_WIDTH = 5;

  function automatic longint sat_max(input int unsigned dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned dw);
    return -(longint'(1) << (dw - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(DEF_DATA_WIDTH);
  localparam longint SAT_MIN = sat_min(DEF_DATA_WIDTH);

endpackage

// File: rtl/conv_output_writer_if.sv
// Accumulator input stream plus SRAM write port of the output writer.
interface conv_output_writer_if #(
  parameter int unsigned ACC_WIDTH  = conv_out_pkg::DEF_ACC_WIDTH,
  parameter int unsigned DATA_WIDTH = conv_out_pkg::DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = conv_out_pkg::DEF_ADDR_WIDTH
);
  logic                         in_valid;
  logic signed [ACC_WIDTH-1:0]  in_data;
  logic                         in_ready;
  logic                         write_req;
  logic        [ADDR_WIDTH-1:0] write_addr;
  logic        [DATA_WIDTH-1:0] write_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, write_req, write_addr, write_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, write_req, write_addr, write_data
  );
endinterface

// File: rtl/conv_round_sat.sv
// Rounding arithmetic right shift followed by saturation to the storage width.
module conv_round_sat
  import conv_out_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = DEF_ACC_WIDTH + 1,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic signed [IN_WIDTH-1:0]    sum_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  output logic signed [DATA_WIDTH-1:0]  data_o,
  output logic                          sat_o
);
  localparam int unsigned EW = IN_WIDTH + 1;
  localparam logic signed [EW-1:0] MAXV = EW'(sat_max(DATA_WIDTH));
  localparam logic signed [EW-1:0] MINV = EW'(sat_min(DATA_WIDTH));

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] r;

  always_comb begin
    ext = {sum_i[IN_WIDTH-1], sum_i};
    rnd = '0;
    if (shift_i != '0) rnd = EW'(1) << (shift_i - SHIFT_WIDTH'(1));
    r      = (ext + rnd) >>> shift_i;
    data_o = r[DATA_WIDTH-1:0];
    sat_o  = 1'b0;
    if (r > MAXV) begin
      data_o = MAXV[DATA_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (r < MINV) begin
      data_o = MINV[DATA_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end
endmodule

// File: rtl/conv_output_writer.sv
// Bias/ReLU/round/saturate post-processing and sequential SRAM write addressing.
module conv_output_writer
  import conv_out_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic        [ADDR_WIDTH-1:0]  base_addr,
  input  logic        [ADDR_WIDTH:0]    num_outputs,
  input  logic signed [ACC_WIDTH-1:0]   bias,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                          relu_en,
  conv_output_writer_if.slave           bus,
  output logic                          busy,
  output logic                          done,
  output logic                          sat_flag
);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  state_t state_q, state_d;

  logic        [ADDR_WIDTH-1:0]  base_q;
  logic        [ADDR_WIDTH:0]    num_q;
  logic        [ADDR_WIDTH:0]    cnt_q;
  logic signed [ACC_WIDTH-1:0]   bias_q;
  logic        [SHIFT_WIDTH-1:0] shift_q;
  logic                          relu_q;
  logic                          sat_q;

  logic                          s1_valid_q;
  logic signed [ACC_WIDTH:0]     s1_sum_q, s1_sum_d;
  logic        [ADDR_WIDTH-1:0]  s1_addr_q;

  logic                          wr_req_q;
  logic        [ADDR_WIDTH-1:0]  wr_addr_q;
  logic        [DATA_WIDTH-1:0]  wr_data_q;

  logic                          start_acc, accept, last_beat;
  logic signed [DATA_WIDTH-1:0]  rs_data;
  logic                          rs_sat;

  assign start_acc = start && (state_q == IDLE);
  assign accept    = bus.in_valid && (state_q == RUN);
  assign last_beat = accept && (cnt_q == num_q - CNT_ONE);

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = (num_outputs == '0) ? DONE : RUN;
      RUN: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // stage 2 empties on the same edge, so the last write precedes done by one cycle
        if (!s1_valid_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    s1_sum_d = {bus.in_data[ACC_WIDTH-1], bus.in_data} + {bias_q[ACC_WIDTH-1], bias_q};
    if (relu_q && s1_sum_d[ACC_WIDTH]) s1_sum_d = '0;
  end

  conv_round_sat #(
    .IN_WIDTH   (ACC_WIDTH + 1),
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_round_sat (
    .sum_i  (s1_sum_q),
    .shift_i(shift_q),
    .data_o (rs_data),
    .sat_o  (rs_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q     <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      bias_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      sat_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_addr_q  <= '0;
      wr_req_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      if (start_acc) begin
        base_q  <= base_addr;
        num_q   <= num_outputs;
        bias_q  <= bias;
        shift_q <= shift;
        relu_q  <= relu_en;
        cnt_q   <= '0;
        sat_q   <= 1'b0;
      end else if (accept) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      s1_valid_q <= accept;
      if (accept) begin
        s1_sum_q  <= s1_sum_d;
        s1_addr_q <= base_q + cnt_q[ADDR_WIDTH-1:0];
      end
      wr_req_q <= s1_valid_q;
      if (s1_valid_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= rs_data;
        if (rs_sat) sat_q <= 1'b1;
      end
    end
  end

  assign bus.write_req  = wr_req_q;
  assign bus.write_addr = wr_addr_q;
  assign bus.write_data = wr_data_q;
  assign sat_flag       = sat_q;
endmodule
